// File: rtl/pio_pkg.sv
// Shared register map for the LED/GPIO output PIO.
package pio_pkg;
    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PORT      = 3'd1;
    localparam logic [2:0] ADDR_BLINK_EN  = 3'd2;
    localparam logic [2:0] ADDR_PERIOD    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
    localparam logic [2:0] ADDR_OUTTOGGLE = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    typedef enum logic [2:0] {
        REG_DATA      = ADDR_DATA,
        REG_PORT      = ADDR_PORT,
        REG_BLINK_EN  = ADDR_BLINK_EN,
        REG_PERIOD    = ADDR_PERIOD,
        REG_OUTSET    = ADDR_OUTSET,
        REG_OUTCLEAR  = ADDR_OUTCLEAR,
        REG_OUTTOGGLE = ADDR_OUTTOGGLE,
        REG_STATUS    = ADDR_STATUS
    } pio_reg_t;
endpackage

// File: rtl/pio_blink_timer.sv
// Blink phase generator: phase toggles every period+1 cycles.
// Latency: restart clears cnt/phase on the same edge.
// Backpressure: none, free-running.
module pio_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);
    logic [PERIOD_W-1:0] cnt;

    // restart outranks a terminal count landing on the same edge
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == period) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pio_led_ctrl.sv
// Avalon-MM output PIO with set/clear/toggle and per-bit hardware blink.
// Latency: zero-wait reads; out_port follows register writes one edge later.
// Backpressure: none, zero-wait-state slave.
module pio_led_ctrl
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PERIOD_W    = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic [WIDTH-1:0]    data_reg;
    logic [WIDTH-1:0]    blink_en;
    logic [PERIOD_W-1:0] period_reg;
    logic                phase;
    logic                wr_en;
    logic                restart;
    logic [WIDTH-1:0]    wd;
    logic                unused_wd;
    pio_reg_t            reg_sel;

    assign reg_sel   = pio_reg_t'(address);
    assign wr_en     = chipselect && !write_n;
    assign restart   = wr_en && (reg_sel == REG_PERIOD);
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg   <= RESET_VALUE;
            blink_en   <= '0;
            period_reg <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_DATA:      data_reg   <= wd;
                REG_BLINK_EN:  blink_en   <= wd;
                REG_PERIOD:    period_reg <= writedata[PERIOD_W-1:0];
                REG_OUTSET:    data_reg   <= data_reg | wd;
                REG_OUTCLEAR:  data_reg   <= data_reg & ~wd;
                REG_OUTTOGGLE: data_reg   <= data_reg ^ wd;
                default:       ;
            endcase
        end
    end

    // Blinking bits are forced low during phase 1
    always_ff @(posedge clk) begin
        if (reset)
            out_port <= RESET_VALUE;
        else
            out_port <= data_reg & ~(blink_en & {WIDTH{phase}});
    end

    pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (period_reg),
        .restart (restart),
        .phase   (phase)
    );

    always_comb begin
        readdata = '0;
        case (reg_sel)
            REG_DATA:     readdata = 32'(data_reg);
            REG_PORT:     readdata = 32'(out_port);
            REG_BLINK_EN: readdata = 32'(blink_en);
            REG_PERIOD:   readdata = 32'(period_reg);
            REG_STATUS:   readdata = {31'b0, phase};
            default:      readdata = '0;
        endcase
    end
endmodule
